// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side handshakes and the memory-port bus for mem_arbiter.
// slave = arbiter view; master = environment (requesters + memory) view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [DATA_W-1:0] i_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_w_o;
  logic [DATA_W-1:0] mem_d_o;
  logic [DATA_W-1:0] mem_q_i;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_a_o, mem_w_o, mem_d_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_a_o, mem_w_o, mem_d_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// D has priority; a saturating starvation counter forces an I grant after STARVE_MAX denials.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [CNT_W-1:0]  starve_cnt;
  logic [1:0]        rd_owner;
  logic [ADDR_W-1:0] a_q;
  logic              i_gnt;
  logic              d_gnt;
  logic              i_starved;

  assign i_starved = bus.i_req_i && (starve_cnt == CNT_MAX);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (bus.d_req_i && !i_starved) d_gnt = 1'b1;
      else if (bus.i_req_i)          i_gnt = 1'b1;
    end
  end

  // Address holds its last driven value when idle so the memory pins do not toggle.
  always_comb begin
    bus.mem_a_o = a_q;
    bus.mem_w_o = 1'b0;
    bus.mem_d_o = '0;
    if (d_gnt) begin
      bus.mem_a_o = bus.d_addr_i;
      bus.mem_w_o = bus.d_we_i;
      bus.mem_d_o = bus.d_wdata_i;
    end else if (i_gnt) begin
      bus.mem_a_o = bus.i_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
      a_q        <= '0;
    end else begin
      a_q <= bus.mem_a_o;
      if (bus.i_req_i && !i_gnt)
        starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      if (d_gnt && !bus.d_we_i) rd_owner <= OWN_D;
      else if (i_gnt)           rd_owner <= OWN_I;
      else                      rd_owner <= OWN_NONE;
    end
  end

  // A read accepted just before reset must not surface while reset is held.
  assign bus.i_gnt_o    = i_gnt;
  assign bus.d_gnt_o    = d_gnt;
  assign bus.i_rvalid_o = !rst && (rd_owner == OWN_I);
  assign bus.d_rvalid_o = !rst && (rd_owner == OWN_D);
  assign bus.i_rdata_o  = bus.mem_q_i;
  assign bus.d_rdata_o  = bus.mem_q_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus contention, reset and idle sequences.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:65535];
  logic [31:0] mem_q = '0;
  always @(posedge clk) begin
    if (bus.mem_w_o) mem[bus.mem_a_o] <= bus.mem_d_o;
    mem_q <= mem[bus.mem_a_o];
  end
  assign bus.mem_q_i = mem_q;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [31:0] dd);
    bus.i_req_i   = ir;
    bus.i_addr_i  = ia;
    bus.d_req_i   = dr;
    bus.d_we_i    = dw;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_w;
    logic [15:0] e_a;
    logic [31:0] e_d;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_q;
  } vec_t;

  vec_t vecs [7];
  int prev;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0001] = 32'h0000000A;
    mem[16'h0002] = 32'h0000000B;
    mem[16'h0003] = 32'h00000033;
    mem[16'h0004] = 32'h00000044;

    //          ir ia       dr dw da       dd            igt dgt w  a        d             irv drv q
    vecs[0] = '{1, 16'h0010, 0, 0, 16'h0000, 32'h0,        1, 0, 0, 16'h0010, 32'h0,        0, 0, 32'h0};
    vecs[1] = '{0, 16'h0000, 1, 1, 16'h0020, 32'h12345678, 0, 1, 1, 16'h0020, 32'h12345678, 1, 0, 32'hDEADBEEF};
    vecs[2] = '{0, 16'h0000, 1, 0, 16'h0020, 32'h0,        0, 1, 0, 16'h0020, 32'h0,        0, 0, 32'h0};
    vecs[3] = '{0, 16'h0000, 1, 0, 16'h0001, 32'h0,        0, 1, 0, 16'h0001, 32'h0,        0, 1, 32'h12345678};
    vecs[4] = '{1, 16'h0002, 0, 0, 16'h0000, 32'h0,        1, 0, 0, 16'h0002, 32'h0,        0, 1, 32'h0000000A};
    vecs[5] = '{0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 16'h0002, 32'h0,        1, 0, 32'h0000000B};
    vecs[6] = '{0, 16'h0000, 0, 0, 16'h0000, 32'h0,        0, 0, 0, 16'h0002, 32'h0,        0, 0, 32'h0};

    // Reset with both requests asserted: no grants, quiet outputs.
    drive(1, 16'h0010, 1, 1, 16'h0020, 32'hFFFFFFFF);
    next_cycle();
    @(negedge clk);
    check("rst_i_gnt", 32'(bus.i_gnt_o), 0);
    check("rst_d_gnt", 32'(bus.d_gnt_o), 0);
    check("rst_i_rvalid", 32'(bus.i_rvalid_o), 0);
    check("rst_d_rvalid", 32'(bus.d_rvalid_o), 0);
    check("rst_mem_w", 32'(bus.mem_w_o), 0);
    check("rst_mem_d", bus.mem_d_o, 0);
    check("rst_mem_a", 32'(bus.mem_a_o), 0);
    check("rst_starve", 32'(dut.starve_cnt), 0);
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;

    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].i_req, vecs[k].i_addr, vecs[k].d_req, vecs[k].d_we, vecs[k].d_addr, vecs[k].d_wdata);
      @(negedge clk);
      check($sformatf("v%0d_i_gnt", k), 32'(bus.i_gnt_o), 32'(vecs[k].e_igt));
      check($sformatf("v%0d_d_gnt", k), 32'(bus.d_gnt_o), 32'(vecs[k].e_dgt));
      check($sformatf("v%0d_mem_w", k), 32'(bus.mem_w_o), 32'(vecs[k].e_w));
      check($sformatf("v%0d_mem_a", k), 32'(bus.mem_a_o), 32'(vecs[k].e_a));
      check($sformatf("v%0d_mem_d", k), bus.mem_d_o, vecs[k].e_d);
      check($sformatf("v%0d_i_rvalid", k), 32'(bus.i_rvalid_o), 32'(vecs[k].e_irv));
      check($sformatf("v%0d_d_rvalid", k), 32'(bus.d_rvalid_o), 32'(vecs[k].e_drv));
      if (vecs[k].e_irv) check($sformatf("v%0d_i_rdata", k), bus.i_rdata_o, vecs[k].e_q);
      if (vecs[k].e_drv) check($sformatf("v%0d_d_rdata", k), bus.d_rdata_o, vecs[k].e_q);
      next_cycle();
    end

    // Continuous contention: D,D,D,D,I repeating; returns follow the previous owner.
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 16'h0003, 1, 0, 16'h0004, 32'h0);
      @(negedge clk);
      check($sformatf("c%0d_i_gnt", k), 32'(bus.i_gnt_o), 32'((k % 5) == 4));
      check($sformatf("c%0d_d_gnt", k), 32'(bus.d_gnt_o), 32'((k % 5) != 4));
      check($sformatf("c%0d_starve", k), 32'(dut.starve_cnt), 32'(k % 5));
      check($sformatf("c%0d_i_rvalid", k), 32'(bus.i_rvalid_o), 32'(prev == 1));
      check($sformatf("c%0d_d_rvalid", k), 32'(bus.d_rvalid_o), 32'(prev == 2));
      if (prev != 0) check($sformatf("c%0d_rdata", k), bus.i_rdata_o, (prev == 1) ? 32'h33 : 32'h44);
      prev = ((k % 5) == 4) ? 1 : 2;
      next_cycle();
    end

    // I read granted, then reset the next cycle: its return is discarded.
    drive(1, 16'h0010, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    check("r_i_gnt", 32'(bus.i_gnt_o), 1);
    check("r_prev_i_rvalid", 32'(bus.i_rvalid_o), 1);
    check("r_prev_rdata", bus.i_rdata_o, 32'h33);
    next_cycle();
    rst = 1'b1;
    drive(1, 16'h0010, 1, 0, 16'h0004, 32'h0);
    @(negedge clk);
    check("r_hold_i_gnt", 32'(bus.i_gnt_o), 0);
    check("r_hold_d_gnt", 32'(bus.d_gnt_o), 0);
    check("r_hold_i_rvalid", 32'(bus.i_rvalid_o), 0);
    check("r_hold_d_rvalid", 32'(bus.d_rvalid_o), 0);
    check("r_hold_starve", 32'(dut.starve_cnt), 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("r_after_i_rvalid", 32'(bus.i_rvalid_o), 0);
    check("r_after_d_rvalid", 32'(bus.d_rvalid_o), 0);
    check("r_after_starve", 32'(dut.starve_cnt), 0);
    check("r_after_mem_a", 32'(bus.mem_a_o), 0);
    next_cycle();

    // Idle for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle%0d_i_gnt", k), 32'(bus.i_gnt_o), 0);
      check($sformatf("idle%0d_d_gnt", k), 32'(bus.d_gnt_o), 0);
      check($sformatf("idle%0d_rvalid", k), 32'({bus.i_rvalid_o, bus.d_rvalid_o}), 0);
      check($sformatf("idle%0d_mem_w", k), 32'(bus.mem_w_o), 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one port of the 32-bit x 64k word memory between the instruction-fetch requester (I) and the execute-stage load/store requester (D). It sits between the ifetch/ex stages and the memory instance. Each cycle it grants at most one access and returns read data one cycle later to the requester that issued the read. Data accesses have priority, and a bounded starvation counter guarantees fetch progress.

## Interface

Synchronous, active-high reset on `rst`; single clock `clk`.

Parameters:
- `ADDR_W`, default 16: word address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: maximum number of consecutive cycles I may be denied while requesting.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active high.
- `i_req_i`  in  1  fetch read request.
- `i_addr_i`  in  ADDR_W  fetch word address.
- `i_gnt_o`  out  1  fetch request accepted this cycle.
- `i_rvalid_o`  out  1  fetch read data valid.
- `i_rdata_o`  out  DATA_W  fetch read data.
- `d_req_i`  in  1  load/store request.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_addr_i`  in  ADDR_W  data word address.
- `d_wdata_i`  in  DATA_W  store data.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  load data valid.
- `d_rdata_o`  out  DATA_W  load data.
- `mem_a_o`  out  ADDR_W  memory address.
- `mem_w_o`  out  1  memory write enable.
- `mem_d_o`  out  DATA_W  memory write data.
- `mem_q_i`  in  DATA_W  memory read data, valid one cycle after the address is sampled.

## Operation

**Request protocol**
- A requester asserts `req` and holds `addr`, `we` and `wdata` stable until the cycle its `gnt` is high.
- Grants are combinational from the current requests and registered state: `i_gnt_o`/`d_gnt_o` are combinational, and at most one is high per cycle.

**Arbitration**
- Only D requests: grant D.
- Only I requests: grant I.
- Both request: grant I if `starve_cnt == STARVE_MAX`, else grant D.
- Neither requests: no grant.

**Memory mux**
- D granted: `mem_a_o = d_addr_i`, `mem_w_o = d_we_i`, `mem_d_o = d_wdata_i`.
- I granted: `mem_a_o = i_addr_i`, `mem_w_o = 0`.
- No grant: `mem_w_o = 0`, `mem_a_o` = last driven value (don't-care), `mem_d_o = 0`.

**Starvation counter** (`starve_cnt`, width clog2(STARVE_MAX+1))
- Increments when `i_req_i && !i_gnt_o`.
- Clears to 0 when `i_gnt_o` or `!i_req_i`.
- Saturates at STARVE_MAX.

**Read-return tracking**
- Registered `rd_owner` records who issued the read accepted in the previous cycle: none, I or D.
- D stores set `rd_owner` = none.
- `i_rvalid_o = (rd_owner == I)`, `d_rvalid_o = (rd_owner == D)`.
- `i_rdata_o = d_rdata_o = mem_q_i`; the rvalid signals qualify them.
- Back-to-back grants to different owners are allowed every cycle; returns never cross.

**Store-then-load ordering**
- A D store granted in cycle n followed by a read of the same address granted in cycle n+1 or later returns the stored value.
- The memory handles this ordering; the arbiter adds no forwarding.

## Timing

- Grant latency: 0 cycles (same cycle as `req`, when arbitration wins).
- Read latency: `rvalid` is asserted exactly 1 cycle after `gnt`, for 1 cycle.
- Throughput: 1 access per cycle total.
- Worst-case I wait under continuous D traffic: STARVE_MAX cycles, with the grant on cycle STARVE_MAX+1.

**Reset values:** `rd_owner` = none, `starve_cnt` = 0, `i_rvalid_o` = 0, `d_rvalid_o` = 0, `mem_w_o` = 0, `mem_d_o` = 0, `mem_a_o` = 0.
- While `rst` is high, both `gnt` outputs are 0 regardless of requests.

**Reset mid-operation:** if a read was granted in the cycle before `rst`, its return is discarded. No `rvalid` is asserted in the cycle after reset.

**Simultaneous grant and request drop:** `req` deasserted in the cycle of `gnt` is legal. The access still completes.

## Test plan

1. **I read only.** Memory[0x0010] = 0xDEADBEEF; `i_req_i` = 1, `i_addr_i` = 0x0010 -> `i_gnt_o` = 1 in the same cycle; next cycle `i_rvalid_o` = 1 and `i_rdata_o` = 0xDEADBEEF; `d_rvalid_o` stays 0.
2. **D store then load.** Store 0x12345678 to 0x0020 -> `mem_w_o` = 1, `mem_a_o` = 0x0020, no `rvalid` follows. Load 0x0020 on the next cycle -> `d_rvalid_o` = 1 with 0x12345678.
3. **Continuous contention**, STARVE_MAX = 4, both requesting every cycle -> grant sequence D,D,D,D,I repeating; `starve_cnt` reads 0,1,2,3,4 then clears to 0.
4. **Alternating owners.** D load of 0x0001 (data 0xA) granted in cycle n, I read of 0x0002 (data 0xB) granted in cycle n+1 -> `d_rvalid_o` in n+1 with 0xA, `i_rvalid_o` in n+2 with 0xB, no overlap.
5. **Reset after a read grant.** Assert `rst` in the cycle after an I read grant -> `i_rvalid_o` = 0 in that cycle and the next; `starve_cnt` = 0; both grants 0 while `rst` is high.
6. **Idle.** Both `req` low for 10 cycles -> no grant, no `rvalid`, `mem_w_o` = 0 every cycle.
